pipe_scoreboard: RTL and testbench

- Parametrised hazard scoreboard for the pipelined MIPS core, sitting beside the ID stage.
- Tracks in-flight register writes across STAGES post-ID pipeline stages (default EX, MA, WB).
- Per cycle, produces per-source forwarding selects and a load-use stall, and handles branch/jump flush.
- Keeps a saturating stall-cycle performance counter.
- Replaces the current no-interlock arrangement, in which software must pad hazards with NOPs.

---
 rtl/pipe_scoreboard.sv | 159 +++++++++++++++
 tb/tb_pipe_scoreboard.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: hazard scoreboard that sits beside the ID stage.
// It records which post-ID stages hold a pending register write and decides,
// in the same cycle, whether each ID source is taken from the register file,
// forwarded from a later stage, or must wait (load-use stall).
// A taken branch/jump flushes the youngest in-flight stages.
// A saturating counter records how many cycles were spent stalled.

module pipe_scoreboard #(
  parameter int REG_AW      = 5,
  parameter int STAGES      = 3,
  parameter int ALU_READY   = 1,
  parameter int LOAD_READY  = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int SEL_W       = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_used,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic [SEL_W:0]    pending_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef logic [STAGES:1][REG_AW-1:0] rd_arr_t;

  // Per-stage bookkeeping; index 1 is EX (youngest), index STAGES is WB.
  logic [STAGES:1] r_valid;
  rd_arr_t         r_rd;
  logic [STAGES:1] r_is_load;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [SEL_W:0]   w_rs_look;
  logic [SEL_W:0]   w_rt_look;
  logic             w_stall;
  logic             w_issue;
  logic [STAGES:1]  w_nxt_valid;
  rd_arr_t          w_nxt_rd;
  logic [STAGES:1]  w_nxt_ld;
  logic [SEL_W:0]   w_pend;

  // Search stages youngest-first for a pending write to src.
  // Returns {stall_request, forward_select}. Register 0 never matches because
  // it is hard-wired zero; an unused source never matches either.
  function automatic logic [SEL_W:0] f_lookup(
    input logic [REG_AW-1:0] src,
    input logic              used,
    input logic [STAGES:1]   vld,
    input rd_arr_t           rd,
    input logic [STAGES:1]   ld
  );
    logic [SEL_W-1:0] sel;
    logic             req;
    logic             found;
    sel   = {SEL_W{1'b0}};
    req   = 1'b0;
    found = 1'b0;
    if (used && (src != {REG_AW{1'b0}})) begin
      for (int k = 1; k <= STAGES; k++) begin
        if (!found && vld[k] && (rd[k] == src)) begin
          found = 1'b1;
          // A load's data exists only from LOAD_READY on; ALU results earlier.
          if (k >= (ld[k] ? LOAD_READY : ALU_READY)) begin
            sel = SEL_W'(k);
          end else begin
            req = 1'b1;
          end
        end else begin
          found = found;
        end
      end
    end else begin
      found = 1'b0;
    end
    return {req, sel};
  endfunction

  // Same-cycle forwarding/stall decision from current state and ID inputs.
  always_comb begin
    w_rs_look = f_lookup(id_rs, id_rs_used, r_valid, r_rd, r_is_load);
    w_rt_look = f_lookup(id_rt, id_rt_used, r_valid, r_rd, r_is_load);
    // A flush discards the ID instruction, so it can never be waited on.
    w_stall   = id_valid && (w_rs_look[SEL_W] || w_rt_look[SEL_W]) && !flush;
    // Only a real, non-stalled, non-flushed writer of a nonzero register enters EX.
    w_issue   = id_valid && id_wr && (id_rd != {REG_AW{1'b0}}) && !w_stall && !flush;
  end

  // Next-state of the stage shift register, including bubble/flush handling.
  always_comb begin
    w_nxt_valid    = r_valid;
    w_nxt_rd       = r_rd;
    w_nxt_ld       = r_is_load;
    w_nxt_valid[1] = w_issue;
    w_nxt_rd[1]    = id_rd;
    w_nxt_ld[1]    = id_is_load;
    for (int k = 2; k <= STAGES; k++) begin
      // Entries younger than the branch are killed as they move on.
      if (flush && ((k - 1) <= FLUSH_DEPTH)) begin
        w_nxt_valid[k] = 1'b0;
      end else begin
        w_nxt_valid[k] = r_valid[k-1];
      end
      w_nxt_rd[k] = r_rd[k-1];
      w_nxt_ld[k] = r_is_load[k-1];
    end
  end

  // Count of stages currently holding a pending write.
  always_comb begin
    w_pend = {(SEL_W+1){1'b0}};
    for (int k = 1; k <= STAGES; k++) begin
      w_pend = w_pend + {{SEL_W{1'b0}}, r_valid[k]};
    end
  end

  // Stage registers: advance every cycle; reset drops all entries at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= {STAGES{1'b0}};
      r_rd      <= '0;
      r_is_load <= {STAGES{1'b0}};
    end else begin
      r_valid   <= w_nxt_valid;
      r_rd      <= w_nxt_rd;
      r_is_load <= w_nxt_ld;
    end
  end

  // Stall-cycle counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall       = w_stall;
  assign fwd_rs_sel  = w_rs_look[SEL_W-1:0];
  assign fwd_rt_sel  = w_rt_look[SEL_W-1:0];
  assign pending_cnt = w_pend;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Testbench for pipe_scoreboard: directed scenarios followed by random
// traffic. Every cycle the expected outputs are computed by an age-based
// reference model and queued; a negedge monitor pops and compares.
// A second instance with a 4-bit counter exercises saturation.

module tb_pipe_scoreboard;

  localparam int REG_AW      = 5;
  localparam int STAGES      = 3;
  localparam int ALU_READY   = 1;
  localparam int LOAD_READY  = 2;
  localparam int FLUSH_DEPTH = 1;
  localparam int SEL_W       = 2;

  logic clk;
  logic reset;
  logic id_valid, id_rs_used, id_rt_used, id_wr, id_is_load, flush, cnt_clr;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;

  logic              stall, stall4;
  logic [SEL_W-1:0]  fwd_rs_sel, fwd_rt_sel, fwd_rs_sel4, fwd_rt_sel4;
  logic [SEL_W:0]    pending_cnt, pending_cnt4;
  logic [15:0]       stall_cnt;
  logic [3:0]        stall_cnt4;

  pipe_scoreboard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_wr(id_wr), .id_rd(id_rd), .id_is_load(id_is_load),
    .flush(flush), .cnt_clr(cnt_clr),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .pending_cnt(pending_cnt), .stall_cnt(stall_cnt)
  );

  pipe_scoreboard #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_wr(id_wr), .id_rd(id_rd), .id_is_load(id_is_load),
    .flush(flush), .cnt_clr(cnt_clr),
    .stall(stall4), .fwd_rs_sel(fwd_rs_sel4), .fwd_rt_sel(fwd_rt_sel4),
    .pending_cnt(pending_cnt4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of in-flight writers, each tagged with its age
  // (cycles since leaving ID, 1 = EX).
  typedef struct {
    logic [REG_AW-1:0] rd;
    bit                ld;
    int                age;
  } ent_t;

  typedef struct {
    int stall;
    int rs;
    int rt;
    int pend;
    int c16;
    int c4;
  } exp_t;

  ent_t m_q[$];
  exp_t exp_q[$];
  int   m_c16, m_c4;
  bit   m_stall;
  int   cyc;
  int   n_chk, n_err;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  function automatic void mlook(input logic [REG_AW-1:0] s, input bit used,
                                output int sel, output bit req);
    int best;
    bit bl;
    sel  = 0;
    req  = 1'b0;
    best = STAGES + 1;
    bl   = 1'b0;
    if (used && s != 0) begin
      foreach (m_q[i]) begin
        if (m_q[i].rd == s && m_q[i].age < best) begin
          best = m_q[i].age;
          bl   = m_q[i].ld;
        end
      end
      if (best <= STAGES) begin
        if (best >= (bl ? LOAD_READY : ALU_READY)) sel = best;
        else req = 1'b1;
      end
    end
  endfunction

  task automatic model_eval();
    exp_t e;
    int   s1, s2;
    bit   r1, r2;
    if (!reset) begin
      m_q.delete();
      m_c16 = 0;
      m_c4  = 0;
    end
    mlook(id_rs, id_rs_used, s1, r1);
    mlook(id_rt, id_rt_used, s2, r2);
    m_stall = id_valid && (r1 || r2) && !flush;
    e.stall = int'(m_stall);
    e.rs    = s1;
    e.rt    = s2;
    e.pend  = m_q.size();
    e.c16   = m_c16;
    e.c4    = m_c4;
    exp_q.push_back(e);
  endtask

  task automatic model_update();
    ent_t n;
    if (flush) begin
      for (int i = m_q.size() - 1; i >= 0; i--)
        if (m_q[i].age <= FLUSH_DEPTH) m_q.delete(i);
    end
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      m_q[i].age = m_q[i].age + 1;
      if (m_q[i].age > STAGES) m_q.delete(i);
    end
    if (id_valid && id_wr && id_rd != 0 && !m_stall && !flush) begin
      n.rd  = id_rd;
      n.ld  = id_is_load;
      n.age = 1;
      m_q.push_back(n);
    end
    if (cnt_clr) begin
      m_c16 = 0;
      m_c4  = 0;
    end else if (m_stall) begin
      if (m_c16 < 65535) m_c16++;
      if (m_c4 < 15) m_c4++;
    end
  endtask

  // Apply one cycle of ID inputs (called just after a rising edge).
  task automatic drive(input bit rst, input bit v, input int rs, input bit rsu,
                       input int rt, input bit rtu, input bit wr, input int rd,
                       input bit ld, input bit fl, input bit clr);
    reset      = rst;
    id_valid   = v;
    id_rs      = REG_AW'(rs);
    id_rs_used = rsu;
    id_rt      = REG_AW'(rt);
    id_rt_used = rtu;
    id_wr      = wr;
    id_rd      = REG_AW'(rd);
    id_is_load = ld;
    flush      = fl;
    cnt_clr    = clr;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_update();
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall",       int'(stall),        e.stall);
      chk("fwd_rs_sel",  int'(fwd_rs_sel),   e.rs);
      chk("fwd_rt_sel",  int'(fwd_rt_sel),   e.rt);
      chk("pending_cnt", int'(pending_cnt),  e.pend);
      chk("stall_cnt",   int'(stall_cnt),    e.c16);
      chk("stall4",      int'(stall4),       e.stall);
      chk("fwd_rs_sel4", int'(fwd_rs_sel4),  e.rs);
      chk("fwd_rt_sel4", int'(fwd_rt_sel4),  e.rt);
      chk("pending4",    int'(pending_cnt4), e.pend);
      chk("stall_cnt4",  int'(stall_cnt4),   e.c4);
    end
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    m_c16 = 0;
    m_c4  = 0;
    reset = 1'b0;
    id_valid = 1'b0; id_rs_used = 1'b0; id_rt_used = 1'b0; id_wr = 1'b0;
    id_is_load = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    @(posedge clk);
    #1;

    // 1: reset held with random ID inputs, then released.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, $urandom_range(0, 7), 1, $urandom_range(0, 7), 1, 1,
            $urandom_range(1, 7), $urandom_range(0, 1), 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_rs_sel", int'(fwd_rs_sel), 0);
    chk("rst_rt_sel", int'(fwd_rt_sel), 0);
    chk("rst_pending", int'(pending_cnt), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    tick();

    // 2: ALU result forwarded from EX, MA, WB, then register file.
    drive(1, 1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("alu_fwd_sel", int'(fwd_rs_sel), (i < 3) ? i + 1 : 0);
      chk("alu_no_stall", int'(stall), 0);
      tick();
    end

    // 3: load-use: one stall, then forward from MA.
    idle(3);
    drive(1, 1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    tick();
    drive(1, 1, 0, 0, 9, 1, 1, 10, 0, 0, 0);
    #1;
    chk("lu_stall", int'(stall), 1);
    tick();
    drive(1, 1, 0, 0, 9, 1, 1, 10, 0, 0, 0);
    #1;
    chk("lu_stall_end", int'(stall), 0);
    chk("lu_rt_sel", int'(fwd_rt_sel), 2);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("lu_pending", int'(pending_cnt), 2);
    tick();

    // 4: youngest writer wins; writes to r0 are ignored.
    idle(3);
    drive(1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    tick();
    drive(1, 1, 4, 1, 4, 1, 0, 0, 0, 0, 0);
    #1;
    chk("young_rs_sel", int'(fwd_rs_sel), 1);
    chk("young_rt_sel", int'(fwd_rt_sel), 1);
    tick();
    idle(3);
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    #1;
    chk("r0_rs_sel", int'(fwd_rs_sel), 0);
    chk("r0_pending", int'(pending_cnt), 0);
    tick();

    // 5: flush kills the youngest stage and overrides a pending stall.
    idle(3);
    drive(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    tick();
    drive(1, 1, 9, 1, 0, 0, 1, 7, 0, 1, 0);
    #1;
    chk("fl_stall", int'(stall), 0);
    tick();
    drive(1, 1, 5, 1, 9, 1, 0, 0, 0, 0, 0);
    #1;
    chk("fl_pending", int'(pending_cnt), 1);
    chk("fl_rs_sel", int'(fwd_rs_sel), 3);
    chk("fl_rt_sel", int'(fwd_rt_sel), 0);
    tick();

    // 6: 20 stall cycles saturate the 4-bit counter; clear beats increment.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
      tick();
      drive(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sat_cnt4", int'(stall_cnt4), 15);
    tick();
    drive(1, 1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    tick();
    drive(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("clr_stall", int'(stall), 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("clr_cnt4", int'(stall_cnt4), 0);
    chk("clr_cnt16", int'(stall_cnt), 0);
    tick();

    // Random traffic, including occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0);
      tick();
    end
    idle(2);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
